// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array input path.
// Tile geometry, lane widths and the feeder state encoding.
package systolic_pkg;

    localparam int ARRAY_SIZE  = 3;
    localparam int DATA_W      = 8;
    localparam int LANE_W      = DATA_W;
    localparam int VEC_W       = ARRAY_SIZE * LANE_W;
    localparam int FEED_CYCLES = 2 * ARRAY_SIZE - 1;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_READY = 2'd1,
        ST_FEED  = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/skew_mux.sv
// Diagonal skew selector for one feed cycle.
// Lane k carries row (t-k) of the tile, zero outside the ramp.
module skew_mux #(
    parameter int ARRAY_SIZE = systolic_pkg::ARRAY_SIZE,
    parameter int DATA_W     = systolic_pkg::DATA_W,
    parameter int T_W        = 3
) (
    input  logic [ARRAY_SIZE*ARRAY_SIZE*DATA_W-1:0] tile,
    input  logic [T_W-1:0]                          t,
    output logic [ARRAY_SIZE*DATA_W-1:0]            vec
);
    import systolic_pkg::*;

    // Pick A[t-k][k] for every lane that is inside the diagonal band
    always_comb begin
        vec = '0;
        for (int k = 0; k < ARRAY_SIZE; k++) begin
            if (int'(t) >= k && (int'(t) - k) < ARRAY_SIZE) begin
                vec[k*DATA_W +: DATA_W] =
                    tile[((int'(t) - k) * ARRAY_SIZE + k) * DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/systolic_input_feeder.sv
// Tile buffer and skewed feeder in front of the systolic array.
// Loads three rows, waits for go, then streams the diagonal.
module systolic_input_feeder #(
    parameter int ARRAY_SIZE = systolic_pkg::ARRAY_SIZE,
    parameter int DATA_W     = systolic_pkg::DATA_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         go,
    output logic                         tile_ready,
    output logic [ARRAY_SIZE*DATA_W-1:0] input_i,
    output logic                         feed_valid,
    output logic                         feed_last
);
    import systolic_pkg::*;

    localparam int ROW_W  = ARRAY_SIZE * DATA_W;
    localparam int TILE_W = ARRAY_SIZE * ROW_W;
    localparam int N_FEED = 2 * ARRAY_SIZE - 1;
    localparam int R_W    = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
    localparam int T_W    = (N_FEED > 1) ? $clog2(N_FEED) : 1;

    localparam logic [R_W-1:0] R_LAST = R_W'(ARRAY_SIZE - 1);
    localparam logic [T_W-1:0] T_LAST = T_W'(N_FEED - 1);

    feeder_state_t      state;
    feeder_state_t      state_nxt;
    logic [R_W-1:0]     r;
    logic [R_W-1:0]     r_nxt;
    logic [T_W-1:0]     t;
    logic [T_W-1:0]     t_nxt;
    logic [T_W-1:0]     t_sel;
    logic [TILE_W-1:0]  tile;
    logic               row_we;
    logic [ROW_W-1:0]   skew_vec;
    logic [ROW_W-1:0]   vec_nxt;
    logic               valid_nxt;
    logic               last_nxt;

    // Upper byte of the bus word carries nothing for a 3-lane tile
    logic unused_hi;
    assign unused_hi = ^in_data[31:ROW_W];

    assign in_ready   = (state == ST_LOAD);
    assign tile_ready = (state == ST_READY);

    skew_mux #(
        .ARRAY_SIZE (ARRAY_SIZE),
        .DATA_W     (DATA_W),
        .T_W        (T_W)
    ) u_skew (
        .tile (tile),
        .t    (t_sel),
        .vec  (skew_vec)
    );

    // Next state, counters and the next registered feed vector
    always_comb begin
        state_nxt = state;
        r_nxt     = r;
        t_nxt     = t;
        t_sel     = '0;
        row_we    = 1'b0;
        vec_nxt   = input_i;
        valid_nxt = feed_valid;
        last_nxt  = feed_last;
        unique case (state)
            ST_LOAD: begin
                if (in_valid) begin
                    row_we = 1'b1;
                    if (r == R_LAST) begin
                        r_nxt     = '0;
                        state_nxt = ST_READY;
                    end else begin
                        r_nxt = r + 1'b1;
                    end
                end
            end
            ST_READY: begin
                if (go) begin
                    state_nxt = ST_FEED;
                    t_nxt     = '0;
                    t_sel     = '0;
                    vec_nxt   = skew_vec;
                    valid_nxt = 1'b1;
                    last_nxt  = (T_LAST == '0);
                end
            end
            ST_FEED: begin
                if (t == T_LAST) begin
                    state_nxt = ST_LOAD;
                    t_nxt     = '0;
                    vec_nxt   = '0;
                    valid_nxt = 1'b0;
                    last_nxt  = 1'b0;
                end else begin
                    t_nxt     = t + 1'b1;
                    t_sel     = t + 1'b1;
                    vec_nxt   = skew_vec;
                    valid_nxt = 1'b1;
                    last_nxt  = ((t + 1'b1) == T_LAST);
                end
            end
            default: begin
                state_nxt = ST_LOAD;
                r_nxt     = '0;
                t_nxt     = '0;
                vec_nxt   = '0;
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
            end
        endcase
    end

    // State, counters, tile buffer and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_LOAD;
            r          <= '0;
            t          <= '0;
            tile       <= '0;
            input_i    <= '0;
            feed_valid <= 1'b0;
            feed_last  <= 1'b0;
        end else begin
            state      <= state_nxt;
            r          <= r_nxt;
            t          <= t_nxt;
            input_i    <= vec_nxt;
            feed_valid <= valid_nxt;
            feed_last  <= last_nxt;
            if (row_we) begin
                tile[int'(r)*ROW_W +: ROW_W] <= in_data[ROW_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_systolic_input_feeder.sv
// Randomized bench for systolic_input_feeder.
// Reference tracks rows held and feed position per cycle.
module tb_systolic_input_feeder;

    localparam int NF = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        go;
    logic        tile_ready;
    logic [23:0] input_i;
    logic        feed_valid;
    logic        feed_last;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          m_rows;
    int          m_feed;
    logic [7:0]  a_ref [3][3];
    int          fl_cyc [$];

    systolic_input_feeder dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .go         (go),
        .tile_ready (tile_ready),
        .input_i    (input_i),
        .feed_valid (feed_valid),
        .feed_last  (feed_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    endtask

    function automatic logic [23:0] skew_ref(int tt);
        logic [23:0] v;
        v = '0;
        for (int k = 0; k < 3; k++) begin
            if (tt - k >= 0 && tt - k < 3) v[k*8 +: 8] = a_ref[tt-k][k];
        end
        return v;
    endfunction

    task automatic model_reset();
        m_rows = 0;
        m_feed = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) a_ref[i][j] = '0;
    endtask

    task automatic check_outs();
        chk("in_ready", 32'(in_ready), 32'(m_feed == 0 && m_rows < 3));
        chk("tile_ready", 32'(tile_ready), 32'(m_feed == 0 && m_rows == 3));
        chk("feed_valid", 32'(feed_valid), 32'(m_feed > 0));
        chk("input_i", 32'(input_i),
            32'((m_feed > 0) ? skew_ref(m_feed - 1) : 24'h0));
        chk("feed_last", 32'(feed_last), 32'(m_feed == NF));
        if (feed_last) fl_cyc.push_back(cyc);
    endtask

    // Called at a falling edge: check, drive, predict, advance one cycle
    task automatic step(input logic v, input logic [31:0] w,
                        input logic g, output bit acc);
        check_outs();
        in_valid = v;
        in_data  = w;
        go       = g;
        acc      = 1'b0;
        if (m_feed > 0) begin
            m_feed = (m_feed == NF) ? 0 : m_feed + 1;
        end else if (m_rows == 3) begin
            if (g) begin
                m_feed = 1;
                m_rows = 0;
            end
        end else if (v) begin
            for (int k = 0; k < 3; k++) a_ref[m_rows][k] = w[k*8 +: 8];
            m_rows++;
            acc = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic rst_checks(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_tile_ready"}, 32'(tile_ready), 32'd0);
        chk({tag, "_input_i"}, 32'(input_i), 32'd0);
        chk({tag, "_feed_valid"}, 32'(feed_valid), 32'd0);
        chk({tag, "_feed_last"}, 32'(feed_last), 32'd0);
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] x;
        x = $urandom();
        return {8'hFF, x[23:0]};
    endfunction

    logic [23:0] basic_exp [5] = '{24'h000001, 24'h000204, 24'h030507,
                                   24'h060800, 24'h090000};

    initial begin
        bit          acc;
        bit          have;
        logic [31:0] cur;
        logic        v;
        logic        g;

        in_valid = 1'b0;
        in_data  = '0;
        go       = 1'b0;
        reset    = 1'b1;
        model_reset();

        // Asynchronous reset in the middle of a cycle
        #7 reset = 1'b0;
        #1 rst_checks("rst0");
        @(negedge clk);
        reset = 1'b1;

        // Basic tile with known data
        step(1'b1, 32'h00030201, 1'b0, acc);
        step(1'b1, 32'h00060504, 1'b0, acc);
        step(1'b1, 32'h00090807, 1'b0, acc);
        step(1'b0, 32'h0, 1'b1, acc);
        for (int i = 0; i < 5; i++) begin
            chk("basic_vec", 32'(input_i), 32'(basic_exp[i]));
            chk("basic_last", 32'(feed_last), 32'(i == 4));
            step(1'b0, 32'h0, 1'b0, acc);
        end
        chk("basic_after", 32'(input_i), 32'd0);

        // go ignored in LOAD, pulsed in READY, held through FEED
        step(1'b1, rnd_word(), 1'b1, acc);
        step(1'b1, rnd_word(), 1'b1, acc);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, acc);
        chk("go_load", 32'(feed_valid), 32'd0);
        step(1'b1, rnd_word(), 1'b1, acc);
        step(1'b0, 32'h0, 1'b0, acc);
        step(1'b0, 32'h0, 1'b0, acc);
        chk("go_wait", 32'(tile_ready), 32'd1);
        step(1'b0, 32'h0, 1'b1, acc);
        chk("go_lat", 32'(feed_valid), 32'd1);
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, acc);

        // Back-to-back tiles with go tied high
        fl_cyc.delete();
        for (int i = 0; i < 22; i++) step(1'b1, rnd_word(), 1'b1, acc);
        chk("b2b_count", 32'(fl_cyc.size() >= 2), 32'd1);
        if (fl_cyc.size() >= 2)
            chk("b2b_period", 32'(fl_cyc[1] - fl_cyc[0]), 32'd9);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0, acc);

        // Reset while t=2 is on the bus
        for (int i = 0; i < 3; i++) step(1'b1, rnd_word(), 1'b0, acc);
        step(1'b0, 32'h0, 1'b1, acc);
        for (int i = 0; i < 10 && m_feed != 3; i++)
            step(1'b0, 32'h0, 1'b0, acc);
        chk("rf_reach", 32'(m_feed), 32'd3);
        #2 reset = 1'b0;
        #1 rst_checks("rst_feed");
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, rnd_word(), 1'b0, acc);
        step(1'b0, 32'h0, 1'b1, acc);
        for (int i = 0; i < 7; i++) step(1'b0, 32'h0, 1'b0, acc);

        // Random backpressure; source holds each word until taken
        have = 1'b0;
        cur  = '0;
        for (int i = 0; i < 400; i++) begin
            if (!have) begin
                cur  = rnd_word();
                have = 1'b1;
            end
            v = ($urandom_range(3) != 0) || (m_feed > 0) || (m_rows == 3);
            g = ($urandom_range(2) == 0);
            step(v, cur, g, acc);
            if (acc) have = 1'b0;
        end
        check_outs();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/systolic_input_feeder.md
# systolic_input_feeder

Upstream stage of the 3×3 systolic array top. It accepts activation rows as 32-bit bus words with a valid/ready handshake and buffers one 3×3 tile. On a `go` strobe it drives the array's 24-bit `input_i` bus with the diagonal skew the array needs: lane k is delayed k cycles, and zeros fill the ramp-in and ramp-out. It also emits framing strobes, so the downstream controller can align its weight-load and run phases with the feed.

## Interface
Parameters:
- `ARRAY_SIZE`, default 3: rows/lanes per tile; RTL verified only at 3.
- `DATA_W`, default 8: element width; `input_i` width is `ARRAY_SIZE*DATA_W` = 24.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_data`  in  32  one activation row: [7:0]=col0, [15:8]=col1, [23:16]=col2; [31:24] ignored.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  feeder accepts a row this cycle.
- `go`  in  1  start the feed; sampled only in READY.
- `tile_ready`  out  1  full tile buffered, waiting for `go`.
- `input_i`  out  24  skewed lane data to the array; lane k = bits [8k+7:8k].
- `feed_valid`  out  1  `input_i` carries a feed cycle.
- `feed_last`  out  1  final feed cycle of the tile.

## Operation
- States:
  - LOAD: `in_ready`=1; accepts rows.
  - READY: `tile_ready`=1; `in_ready`=0.
  - FEED: `in_ready`=0; drives the skewed tile.
- LOAD:
  - A row is accepted when `in_valid && in_ready`.
  - Row counter `r` runs 0..2 and writes buffer row A[r].
  - On the accept with r=2, go to READY and clear r.
- READY:
  - `go`=1 moves to FEED with feed counter t=0.
  - `go` has no effect in LOAD or FEED; it is not latched.
- FEED:
  - Lasts 2·ARRAY_SIZE−1 = 5 cycles, t=0..4.
  - Lane k during feed cycle t carries A[t−k][k] when 0 ≤ t−k < 3, else 0.
  - `feed_last`=1 when t=4. On the following edge, go to LOAD.
- `in_valid` during READY/FEED is not accepted; the upstream source holds the word.
- The buffer is not cleared between tiles. Every tile overwrites all three rows before READY.
- Asynchronous reset (`reset`=0), including mid-LOAD or mid-FEED:
  - State returns to LOAD; r=0, t=0; buffer cleared.
  - `in_ready`=1; `tile_ready`=0; `input_i`=0; `feed_valid`=0; `feed_last`=0.
  - A partially fed tile is dropped and the partial load is discarded.

## Timing
- `input_i`, `feed_valid` and `feed_last` are registered outputs.
- `in_ready` and `tile_ready` are decoded from the state register.
- The edge that samples `go`=1 in READY loads `input_i` with the t=0 vector. Latency from `go` to the first feed vector is 1 cycle.
- `feed_valid` is high for exactly 5 consecutive cycles per tile.
- The edge that ends t=4 zeroes `input_i`, `feed_valid` and `feed_last`, and raises `in_ready`.
- Back-to-back tiles:
  - The first row of the next tile can be accepted in the first cycle after `feed_last`.
  - Minimum tile period is 3 (load) + 1 (READY with `go` high) + 5 (feed) = 9 cycles.
- A third-row accept moves LOAD to READY on the same edge; `tile_ready` rises the next cycle.

## Structure
- Shared package `systolic_pkg` holds:
  - `ARRAY_SIZE`, `DATA_W`, `LANE_W`;
  - the feeder state enum (LOAD/READY/FEED);
  - `FEED_CYCLES` = 2·ARRAY_SIZE−1.
- One sub-module, `skew_mux`: combinational; tile buffer plus t in, skewed 24-bit vector out.
- FSM, counters and output registers live in `systolic_input_feeder`.

## Test plan
- Reset values: assert `reset`=0 asynchronously mid-cycle -> immediately `in_ready`=1, `tile_ready`=0, `input_i`=0, `feed_valid`=0, `feed_last`=0.
- Basic tile:
  - Load rows 32'h00030201, 32'h00060504, 32'h00090807, then `go`.
  - `input_i` must be 24'h000001, 24'h000204, 24'h030507, 24'h060800, 24'h090000.
  - `feed_last` only on the last of these; then `input_i`=0.
- Backpressure:
  - Toggle `in_valid` randomly and hold `in_valid`=1 through READY/FEED.
  - Exactly 3 words accepted per tile; no word lost or duplicated; byte [31:24]=8'hFF has no effect.
- `go` gating:
  - `go`=1 during LOAD with 2 rows loaded -> no feed.
  - `go` pulsed in READY -> feed starts 1 cycle later.
  - `go` held high through FEED -> no restart.
- Back-to-back:
  - Two tiles with `go` tied high.
  - Total period 9 cycles; second tile output matches the expected skew of its own data.
- Reset mid-FEED at t=2 -> outputs zero at once; the next full tile feeds correctly from t=0.
